// File: rtl/shift_step_sequencer.sv
// Multi-cycle front end for the 8-bit combinational shifter: applies a 0..31
// position shift as chunks of at most 8 and returns the result over valid/ready.
module shift_step_sequencer #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_lr,
   input  logic             in_ar,
   input  logic             in_rot,
   output logic [WIDTH-1:0] sh_i,
   output logic [3:0]       sh_n,
   output logic             sh_lr,
   output logic             sh_ar,
   output logic             sh_rot,
   input  logic [WIDTH-1:0] sh_o,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_STEP = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [AMT_W-1:0] MAX_CHUNK = AMT_W'(8);

   logic [1:0]       state;
   logic [WIDTH-1:0] work;
   logic [AMT_W-1:0] remaining;
   logic             lr_q;
   logic             ar_q;
   logic             rot_q;

   logic             accept;
   logic [AMT_W-1:0] eff_amt;
   logic [AMT_W-1:0] rem_next;
   logic [3:0]       chunk;

   assign in_ready  = (state == S_IDLE);
   assign accept    = in_valid & in_ready;
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DONE);
   assign out_data  = (state == S_DONE) ? work : '0;

   // Outside STEP the shifter sees a zero amount, so sh_o simply mirrors work.
   assign sh_i   = work;
   assign sh_n   = (state == S_STEP) ? chunk : 4'd0;
   assign sh_lr  = lr_q;
   assign sh_ar  = ar_q;
   assign sh_rot = rot_q;

   // NOTE: every variable written here gets a default first, so no path can
   // leave it holding its old value and infer a latch.
   always_comb begin
      chunk = remaining[3:0];
      if (remaining > MAX_CHUNK) begin
         chunk = 4'd8;
      end
      // A rotate by a multiple of 8 is the identity, so only the low bits matter.
      eff_amt = in_amt;
      if (in_rot) begin
         eff_amt = {{(AMT_W-3){1'b0}}, in_amt[2:0]};
      end
      rem_next = remaining - AMT_W'(chunk);
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         work      <= '0;
         remaining <= '0;
         lr_q      <= 1'b0;
         ar_q      <= 1'b0;
         rot_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  work      <= in_data;
                  remaining <= eff_amt;
                  lr_q      <= in_lr;
                  ar_q      <= in_ar;
                  rot_q     <= in_rot;
                  state     <= (eff_amt != '0) ? S_STEP : S_DONE;
               end
            end
            S_STEP: begin
               work      <= sh_o;
               remaining <= rem_next;
               if (rem_next == '0) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/shift_step_sequencer.md
Name: shift_step_sequencer

Overview:
- Multi-cycle command front end sitting directly upstream of the team's combinational 8-bit left/right shifter/rotator.
- Accepts one shift command through a valid/ready handshake with an amount of 0..31.
- Each cycle it drives the shifter with a chunk of at most 8 positions and captures the shifter result back into a working register.
- When the full amount has been applied, it presents the result through a valid/ready output.

Parameters:
- WIDTH, 8, data width; fixed to the shifter width and not otherwise supported.
- AMT_W, 5, width of the requested shift amount (0..2^AMT_W-1).

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous active-low reset
- in_valid  input  1  command present
- in_ready  output  1  sequencer can accept a command
- in_data  input  WIDTH  operand
- in_amt  input  AMT_W  total shift amount
- in_lr  input  1  1 = left, 0 = right
- in_ar  input  1  1 = arithmetic (sign fill on right shifts)
- in_rot  input  1  1 = rotate; overrides in_ar
- sh_i  output  WIDTH  operand to shifter
- sh_n  output  4  chunk amount to shifter, 0..8
- sh_lr, sh_ar, sh_rot  output  1 each  mode bits to shifter
- sh_o  input  WIDTH  shifter result, combinational from sh_*
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  final result
- busy  output  1  high in STEP or DONE

Behaviour:
- Reset is asynchronous on nrst low and clears everything:
  - state = IDLE
  - working register, remaining counter and mode registers = 0
  - out_valid = 0, out_data = 0, busy = 0, in_ready = 1 once nrst is released
  - sh_i = 0, sh_n = 0, sh_* mode bits = 0
- States: IDLE, STEP, DONE.
- in_ready = (state == IDLE).
- Accept condition: in_valid & in_ready at a rising edge.
- On accept, the sequencer latches in_data into the working register and latches the mode bits.
- The effective amount is latched into the remaining counter:
  - rot = 1: in_amt[2:0] (modulo 8).
  - rot = 0: in_amt.
- Next state after accept: STEP if the effective amount != 0, else DONE.
- STEP:
  - chunk = min(remaining, 8).
  - sh_i = working register, sh_n = chunk, sh_* = latched modes.
  - At the clock edge: working <= sh_o and remaining <= remaining - chunk.
  - When the new remaining value is 0, next state = DONE; otherwise stay in STEP.
- Latency from accept to out_valid is 1 + ceil(eff/8) cycles:
  - eff = 0 gives out_valid on the cycle after accept.
  - eff = 31 needs 4 STEP cycles.
- Shifter contract per chunk k (the shifter supports 0..8):
  - Left shift by 8 yields 0.
  - Logical right shift by 8 yields 0.
  - Arithmetic right shift by 8 yields all sign bits.
  - Shifts greater than 8 therefore saturate correctly across chunks.
- Outside STEP: sh_n = 0 and sh_i = working register, so the shifter passes the value through unchanged.
- DONE:
  - out_valid = 1 and out_data = working register.
  - Both hold stable until out_ready is sampled high.
  - out_ready high at an edge: next state = IDLE and out_valid drops.
  - No command is accepted in the same cycle as the result is consumed; in_ready rises the cycle after.
- Backpressure: the DONE state holds indefinitely with out_ready low; no value changes.
- in_valid in STEP/DONE is ignored (in_ready low); the upstream holds the command.
- Mode bits are latched at accept; later changes on the in_* inputs have no effect on a command in flight.
- Reset mid-operation aborts the command immediately; no partial result is ever presented.
- Arithmetic: the remaining counter is AMT_W bits, never underflows, and the chunk never exceeds 8.

Test Plan:
- Left logical, in_data=0x81, amt=3 -> 1 STEP with sh_n=3; out_data=0x08, out_valid on cycle 2 after accept.
- Right arithmetic, in_data=0x90, amt=20 -> 3 STEPs with sh_n=8,8,4; out_data=0xFF. Repeat with ar=0 and in_data=0xF0, amt=4 -> out_data=0x0F.
- Rotate left, in_data=0x81, amt=9 -> eff=1, 1 STEP; out_data=0x03. Rotate right, amt=1 -> out_data=0xC0. Rotate, amt=16 -> 0 STEPs; out_data=0x81.
- amt=0, logical left, in_data=0x5A -> no STEP; out_valid the cycle after accept; out_data=0x5A.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, and a new in_valid is not accepted; release out_ready -> IDLE next cycle.
- Drop nrst during the 2nd STEP of an amt=20 command -> all outputs 0 immediately and in_ready=1 after release; the next command completes correctly.
